// File: rtl/multdiv_issue.sv
// Issue stage for the multdiv unit: accepts one mult/div request, pulses multdiv once,
// waits for data_resultRDY (with a watchdog) and hands back result, exception and tag.
module multdiv_issue #(
    parameter int TAG_W   = 5,
    parameter int TIMEOUT = 64
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_is_div,
    input  logic [31:0]      req_opA,
    input  logic [31:0]      req_opB,
    input  logic [TAG_W-1:0] req_tag,
    output logic [31:0]      md_operandA,
    output logic [31:0]      md_operandB,
    output logic             md_ctrl_MULT,
    output logic             md_ctrl_DIV,
    input  logic [31:0]      md_result,
    input  logic             md_exception,
    input  logic             md_resultRDY,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_result,
    output logic             rsp_exception,
    output logic             rsp_timeout,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             busy
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

    state_t           state;
    state_t           next_state;
    logic [31:0]      op_a;
    logic [31:0]      op_b;
    logic [TAG_W-1:0] tag_q;
    logic [CNT_W-1:0] count;
    logic             accept;
    logic             expired;

    assign accept      = (state == IDLE) && req_valid;
    assign expired     = (count == CNT_LAST);
    assign req_ready   = (state == IDLE);
    assign busy        = (state != IDLE);
    assign md_operandA = op_a;
    assign md_operandB = op_b;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // RDY is deliberately not looked at in START: it may still be high from the previous op.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (req_valid) next_state = START;
            START:   next_state = WAIT;
            WAIT:    if (md_resultRDY || expired) next_state = DONE;
            DONE:    if (rsp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            op_a          <= '0;
            op_b          <= '0;
            tag_q         <= '0;
            md_ctrl_MULT  <= 1'b0;
            md_ctrl_DIV   <= 1'b0;
            count         <= '0;
            rsp_valid     <= 1'b0;
            rsp_result    <= '0;
            rsp_exception <= 1'b0;
            rsp_timeout   <= 1'b0;
            rsp_tag       <= '0;
        end else begin
            md_ctrl_MULT <= 1'b0;
            md_ctrl_DIV  <= 1'b0;
            if (accept) begin
                op_a         <= req_opA;
                op_b         <= req_opB;
                tag_q        <= req_tag;
                md_ctrl_DIV  <= req_is_div;
                md_ctrl_MULT <= ~req_is_div;
            end
            case (state)
                START: count <= '0;
                WAIT: begin
                    // A real result wins over the watchdog when both land in the same cycle.
                    if (md_resultRDY) begin
                        rsp_valid     <= 1'b1;
                        rsp_result    <= md_result;
                        rsp_exception <= md_exception;
                        rsp_timeout   <= 1'b0;
                        rsp_tag       <= tag_q;
                    end else if (expired) begin
                        rsp_valid     <= 1'b1;
                        rsp_result    <= '0;
                        rsp_exception <= 1'b1;
                        rsp_timeout   <= 1'b1;
                        rsp_tag       <= tag_q;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                DONE: if (rsp_ready) rsp_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multdiv_issue.sv
// Directed bench for multdiv_issue; the bench itself plays multdiv, raising RDY by hand.
module tb_multdiv_issue;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_div;
    logic [31:0] req_opA;
    logic [31:0] req_opB;
    logic [4:0]  req_tag;
    logic [31:0] md_operandA;
    logic [31:0] md_operandB;
    logic        md_ctrl_MULT;
    logic        md_ctrl_DIV;
    logic [31:0] md_result;
    logic        md_exception;
    logic        md_resultRDY;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_exception;
    logic        rsp_timeout;
    logic [4:0]  rsp_tag;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;

    multdiv_issue #(.TAG_W(5), .TIMEOUT(64)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_div(req_is_div),
        .req_opA(req_opA), .req_opB(req_opB), .req_tag(req_tag),
        .md_operandA(md_operandA), .md_operandB(md_operandB),
        .md_ctrl_MULT(md_ctrl_MULT), .md_ctrl_DIV(md_ctrl_DIV),
        .md_result(md_result), .md_exception(md_exception), .md_resultRDY(md_resultRDY),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_exception(rsp_exception), .rsp_timeout(rsp_timeout), .rsp_tag(rsp_tag),
        .busy(busy)
    );

    always #5 clock = ~clock;

    task step;
        @(negedge clock);
    endtask

    // Presents a request for one cycle; returns at the negedge of the START cycle.
    task start_op(input logic div, input logic [31:0] a, input logic [31:0] b, input logic [4:0] t);
        req_valid  = 1'b1;
        req_is_div = div;
        req_opA    = a;
        req_opB    = b;
        req_tag    = t;
        step;
        req_valid  = 1'b0;
    endtask

    task give_rdy(input logic [31:0] res, input logic exc);
        md_resultRDY = 1'b1;
        md_result    = res;
        md_exception = exc;
        step;
        md_resultRDY = 1'b0;
    endtask

    task take_rsp;
        rsp_ready = 1'b1;
        step;
        rsp_ready = 1'b0;
    endtask

    task test_reset;
        reset_n = 1'b0;
        step;
        step;
        vectors++;
        if ({busy, rsp_valid, md_ctrl_MULT, md_ctrl_DIV, rsp_exception, rsp_timeout} !== 6'b0 ||
            rsp_result !== 32'd0 || rsp_tag !== 5'd0 || md_operandA !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_state: busy=%b rsp_valid=%b mult=%b div=%b result=%h tag=%0d opA=%h, required all zero",
                     busy, rsp_valid, md_ctrl_MULT, md_ctrl_DIV, rsp_result, rsp_tag, md_operandA);
        end
        reset_n = 1'b1;
        step;
        vectors++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_release: req_ready=%b busy=%b, required 1/0", req_ready, busy);
        end
    endtask

    task test_mult;
        start_op(1'b0, 32'd6, 32'd7, 5'd3);
        md_resultRDY = 1'b1;
        md_result    = 32'hDEAD_BEEF;
        md_exception = 1'b1;
        vectors++;
        if (md_ctrl_MULT !== 1'b1 || md_ctrl_DIV !== 1'b0 || md_operandA !== 32'd6 ||
            md_operandB !== 32'd7 || busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL mult_pulse: mult=%b div=%b opA=%0d opB=%0d busy=%b, required 1 0 6 7 1",
                     md_ctrl_MULT, md_ctrl_DIV, md_operandA, md_operandB, busy);
        end
        step;
        md_resultRDY = 1'b0;
        vectors++;
        if (md_ctrl_MULT !== 1'b0 || rsp_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL mult_stale_rdy: mult=%b rsp_valid=%b, required 0/0", md_ctrl_MULT, rsp_valid);
        end
        step;
        give_rdy(32'd42, 1'b0);
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_result !== 32'd42 || rsp_exception !== 1'b0 ||
            rsp_timeout !== 1'b0 || rsp_tag !== 5'd3) begin
            miscompares++;
            $display("[TB] FAIL mult_rsp: valid=%b result=%0d exc=%b to=%b tag=%0d, required 1 42 0 0 3",
                     rsp_valid, rsp_result, rsp_exception, rsp_timeout, rsp_tag);
        end
        take_rsp;
        vectors++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL mult_release: rsp_valid=%b req_ready=%b, required 0/1", rsp_valid, req_ready);
        end
    endtask

    task test_div;
        rsp_ready = 1'b1;
        start_op(1'b1, 32'hFFFF_FF9C, 32'd7, 5'd9);
        vectors++;
        if (md_ctrl_DIV !== 1'b1 || md_ctrl_MULT !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL div_pulse: div=%b mult=%b, required 1/0", md_ctrl_DIV, md_ctrl_MULT);
        end
        step;
        step;
        give_rdy(32'hFFFF_FFF2, 1'b0);
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_result !== 32'hFFFF_FFF2 || rsp_exception !== 1'b0 || rsp_tag !== 5'd9) begin
            miscompares++;
            $display("[TB] FAIL div_rsp: valid=%b result=%h exc=%b tag=%0d, required 1 fffffff2 0 9",
                     rsp_valid, rsp_result, rsp_exception, rsp_tag);
        end
        step;
        rsp_ready = 1'b0;
        vectors++;
        if (rsp_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL div_release: rsp_valid=%b, required 0", rsp_valid);
        end
    endtask

    task test_div_zero;
        start_op(1'b1, 32'd5, 32'd0, 5'd1);
        step;
        give_rdy(32'd0, 1'b1);
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_exception !== 1'b1 || rsp_result !== 32'd0 || rsp_timeout !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL divzero_rsp: valid=%b exc=%b result=%h to=%b, required 1 1 0 0",
                     rsp_valid, rsp_exception, rsp_result, rsp_timeout);
        end
        take_rsp;
    endtask

    task test_overflow;
        start_op(1'b0, 32'h4000_0000, 32'd4, 5'd2);
        step;
        step;
        give_rdy(32'd0, 1'b1);
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_exception !== 1'b1 || rsp_timeout !== 1'b0 || rsp_tag !== 5'd2) begin
            miscompares++;
            $display("[TB] FAIL overflow_rsp: valid=%b exc=%b to=%b tag=%0d, required 1 1 0 2",
                     rsp_valid, rsp_exception, rsp_timeout, rsp_tag);
        end
        take_rsp;
    endtask

    task test_back_to_back;
        start_op(1'b0, 32'd3, 32'd5, 5'd4);
        step;
        give_rdy(32'd15, 1'b0);
        req_valid  = 1'b1;
        req_is_div = 1'b1;
        req_opA    = 32'd50;
        req_opB    = 32'd5;
        req_tag    = 5'd6;
        for (int i = 0; i < 10; i++) begin
            vectors++;
            if (rsp_valid !== 1'b1 || rsp_result !== 32'd15 || rsp_tag !== 5'd4 || rsp_exception !== 1'b0 ||
                req_ready !== 1'b0 || busy !== 1'b1 || md_operandA !== 32'd3) begin
                miscompares++;
                $display("[TB] FAIL hold_cycle%0d: valid=%b result=%0d tag=%0d exc=%b req_ready=%b busy=%b opA=%0d, required 1 15 4 0 0 1 3",
                         i, rsp_valid, rsp_result, rsp_tag, rsp_exception, req_ready, busy, md_operandA);
            end
            step;
        end
        take_rsp;
        vectors++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL hold_release: rsp_valid=%b req_ready=%b, required 0/1", rsp_valid, req_ready);
        end
        step;
        req_valid = 1'b0;
        vectors++;
        if (md_ctrl_DIV !== 1'b1 || md_operandA !== 32'd50 || md_operandB !== 32'd5) begin
            miscompares++;
            $display("[TB] FAIL next_accept: div=%b opA=%0d opB=%0d, required 1 50 5", md_ctrl_DIV, md_operandA, md_operandB);
        end
        step;
        give_rdy(32'd10, 1'b0);
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_result !== 32'd10 || rsp_tag !== 5'd6) begin
            miscompares++;
            $display("[TB] FAIL next_rsp: valid=%b result=%0d tag=%0d, required 1 10 6", rsp_valid, rsp_result, rsp_tag);
        end
        take_rsp;
    endtask

    task test_timeout;
        int early;
        early = -1;
        start_op(1'b0, 32'd1, 32'd1, 5'd7);
        step;
        for (int k = 0; k < 64; k++) begin
            if (rsp_valid !== 1'b0 && early < 0) early = k;
            step;
        end
        vectors++;
        if (early >= 0) begin
            miscompares++;
            $display("[TB] FAIL timeout_early: rsp_valid rose %0d cycles into WAIT, required 64", early);
        end
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_timeout !== 1'b1 || rsp_exception !== 1'b1 ||
            rsp_result !== 32'd0 || rsp_tag !== 5'd7) begin
            miscompares++;
            $display("[TB] FAIL timeout_rsp: valid=%b to=%b exc=%b result=%h tag=%0d, required 1 1 1 0 7",
                     rsp_valid, rsp_timeout, rsp_exception, rsp_result, rsp_tag);
        end
        take_rsp;
    endtask

    task test_reset_mid_op;
        start_op(1'b1, 32'd8, 32'd2, 5'd5);
        step;
        step;
        step;
        reset_n = 1'b0;
        #1;
        vectors++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0 || md_ctrl_DIV !== 1'b0 || md_ctrl_MULT !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL midop_reset: busy=%b rsp_valid=%b div=%b mult=%b, required all 0",
                     busy, rsp_valid, md_ctrl_DIV, md_ctrl_MULT);
        end
        step;
        reset_n = 1'b1;
        step;
        start_op(1'b0, 32'd2, 32'd2, 5'd1);
        vectors++;
        if (md_ctrl_MULT !== 1'b1 || md_ctrl_DIV !== 1'b0 || md_operandA !== 32'd2) begin
            miscompares++;
            $display("[TB] FAIL post_reset_pulse: mult=%b div=%b opA=%0d, required 1 0 2", md_ctrl_MULT, md_ctrl_DIV, md_operandA);
        end
        step;
        give_rdy(32'd4, 1'b0);
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_result !== 32'd4 || rsp_tag !== 5'd1) begin
            miscompares++;
            $display("[TB] FAIL post_reset_rsp: valid=%b result=%0d tag=%0d, required 1 4 1", rsp_valid, rsp_result, rsp_tag);
        end
        take_rsp;
    endtask

    initial begin
        reset_n      = 1'b0;
        req_valid    = 1'b0;
        req_is_div   = 1'b0;
        req_opA      = '0;
        req_opB      = '0;
        req_tag      = '0;
        md_result    = '0;
        md_exception = 1'b0;
        md_resultRDY = 1'b0;
        rsp_ready    = 1'b0;
        test_reset;
        test_mult;
        test_div;
        test_div_zero;
        test_overflow;
        test_back_to_back;
        test_timeout;
        test_reset_mid_op;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
